// File: rtl/lzc_seq_pkg.sv
// Shared constants, FSM state type and width helper for the wide sequential LZC.
package lzc_seq_pkg;

    localparam int unsigned LZC_WORD_W = 32;
    localparam int unsigned MAX_WORDS  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Count field width able to hold 0..32*words inclusive.
    function automatic int unsigned cnt_w(input int unsigned words);
        return $clog2(LZC_WORD_W * words + 1);
    endfunction

endpackage

// File: rtl/lzc32b_2022.sv
// 32-bit leading-zero counter: v flags an all-zero word, z is the count when v=0.
module lzc32b_2022 (
    input  logic [31:0] data,
    output logic        v,
    output logic [4:0]  z
);

    logic found;

    // Priority scan from the MSB; the first set bit fixes the count.
    always_comb begin
        v     = (data == '0);
        z     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (!found && data[31 - i]) begin
                found = 1'b1;
                z     = 5'(i);
            end
        end
    end

endmodule

// File: rtl/lzc_wide_seq_module.sv
// Multi-cycle leading-zero counter for 32*WORDS-bit operands: one shared
// 32-bit LZC walks the operand MSW first and stops at the first non-zero word.
module lzc_wide_seq_module
    import lzc_seq_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  ivalid,
    input  logic                  iready,
    output logic                  ovalid,
    output logic                  oready,
    input  logic [32*WORDS-1:0]   datain_a,
    output logic [31:0]           dataout
);

    localparam int unsigned CNT_W = cnt_w(WORDS);
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(LZC_WORD_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LZC_WORD_W * WORDS);

    if (WORDS < 1 || WORDS > MAX_WORDS) begin : g_bad_words
        $error("lzc_wide_seq_module: WORDS must be in 1..16");
    end

    state_t                state;
    logic [32*WORDS-1:0]   op_q;
    logic [IDX_W-1:0]      idx;
    logic [CNT_W-1:0]      acc;
    logic [31:0]           word;
    logic                  word_zero;
    logic [4:0]            word_lz;

    assign oready = (state == IDLE) & resetn;

    assign word = op_q[LZC_WORD_W * idx +: LZC_WORD_W];

    lzc32b_2022 u_lzc (
        .data (word),
        .v    (word_zero),
        .z    (word_lz)
    );

    // Operand capture on accept; contents are don't-care outside SCAN.
    always_ff @(posedge clock) begin
        if (ivalid && oready) begin
            op_q <= datain_a;
        end
    end

    // Control FSM: accept, scan one word per cycle, hold result until popped.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= IDLE;
            ovalid  <= 1'b0;
            dataout <= '0;
            idx     <= IDX_TOP;
            acc     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ivalid) begin
                        idx   <= IDX_TOP;
                        acc   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (!word_zero) begin
                        dataout <= 32'(acc + CNT_W'(word_lz));
                        ovalid  <= 1'b1;
                        state   <= DONE;
                    end else if (idx != '0) begin
                        acc <= acc + CNT_STEP;
                        idx <= idx - 1'b1;
                    end else begin
                        dataout <= {1'b1, 31'(CNT_FULL)};
                        ovalid  <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (iready) begin
                        ovalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
